// File: rtl/pool_window_gen.sv
// pool_window_gen: turns a raster-order pixel stream into non-overlapping
// 2x2 windows (stride 2) for the average-pool stage.
//
// Stream protocol: valid-only, no backpressure. A pixel is consumed on every
// rising edge where In_Valid=1 and Reset=0. Out_Valid is a one-cycle pulse;
// the window outputs hold their last value while Out_Valid=0.
//
// Ports keep the upper-case names that the pool stage wiring expects.
module pool_window_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  In_Valid,
    input  logic [DATA_WIDTH-1:0] In_Value,
    output logic                  Out_Valid,
    output logic [DATA_WIDTH-1:0] Window_Value_1,
    output logic [DATA_WIDTH-1:0] Window_Value_2,
    output logic [DATA_WIDTH-1:0] Window_Value_3,
    output logic [DATA_WIDTH-1:0] Window_Value_4,
    output logic                  Frame_Done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] held;
    logic [DATA_WIDTH-1:0] line_buf [IMG_WIDTH];

    logic                  accept;
    logic                  col_wrap;
    logic                  frame_last;
    logic [CW-1:0]         col_left;

    // Decode of the current pixel position; col is odd when a window closes,
    // so the left column is col with bit 0 cleared.
    always_comb begin
        accept     = In_Valid && !Reset;
        col_wrap   = (col == COL_LAST);
        frame_last = col_wrap && (row == ROW_LAST);
        col_left   = col ^ CW'(1);
    end

    // Raster position counters: advance only on accepted pixels.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            col <= '0;
            row <= '0;
        end else if (In_Valid) begin
            if (col_wrap) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffer: even rows are stored, odd rows only read it, so no
    // read/write collision is possible. Contents need no reset because every
    // entry is rewritten before the next odd row reads it.
    always_ff @(posedge Clock) begin
        if (accept && !row[0]) begin
            line_buf[col] <= In_Value;
        end
    end

    // Held left pixel of the bottom row and the registered window outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            held           <= '0;
            Out_Valid      <= 1'b0;
            Frame_Done     <= 1'b0;
            Window_Value_1 <= '0;
            Window_Value_2 <= '0;
            Window_Value_3 <= '0;
            Window_Value_4 <= '0;
        end else begin
            Out_Valid  <= 1'b0;
            Frame_Done <= 1'b0;
            if (In_Valid && row[0]) begin
                if (!col[0]) begin
                    held <= In_Value;
                end else begin
                    Window_Value_1 <= line_buf[col_left];
                    Window_Value_2 <= line_buf[col];
                    Window_Value_3 <= held;
                    Window_Value_4 <= In_Value;
                    Out_Valid      <= 1'b1;
                    Frame_Done     <= frame_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen: scoreboard bench for pool_window_gen. A 4x4 instance
// covers the streaming, gap, multi-frame and reset cases; a default 8x8
// instance covers the bit-exact alternating-pattern frame.
module tb_pool_window_gen;

    localparam int DW   = 32;
    localparam int SB_W = 4 * DW + 1;  // {V1,V2,V3,V4,Frame_Done}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          iv4, iv8;
    logic [DW-1:0] in4, in8;
    logic          ov4, ov8, fd4, fd8;
    logic [DW-1:0] a1, a2, a3, a4;
    logic [DW-1:0] b1, b2, b3, b4;

    pool_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut4 (
        .Clock(clk), .Reset(rst), .In_Valid(iv4), .In_Value(in4),
        .Out_Valid(ov4), .Window_Value_1(a1), .Window_Value_2(a2),
        .Window_Value_3(a3), .Window_Value_4(a4), .Frame_Done(fd4)
    );

    pool_window_gen u_dut8 (
        .Clock(clk), .Reset(rst), .In_Valid(iv8), .In_Value(in8),
        .Out_Valid(ov8), .Window_Value_1(b1), .Window_Value_2(b2),
        .Window_Value_3(b3), .Window_Value_4(b4), .Frame_Done(fd8)
    );

    // ---------------- scoreboard ----------------
    logic [SB_W-1:0] exp4_q[$];
    logic [SB_W-1:0] exp8_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [SB_W-1:0] got,
                            input logic [SB_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drives npix pixels of a w x h frame into the selected instance and pushes
    // the expected window whenever a bottom-right pixel (odd row, odd col) goes out.
    // mode 0: pixel = base + index; mode 1: FFFFFFFF / 00000000 alternating.
    task automatic drive_frame(input int dut, input int w, input int h, input int npix,
                               input int base, input int mode, input int gap);
        logic [DW-1:0] pix [64];
        for (int idx = 0; idx < npix; idx++) begin
            int r, c;
            r = idx / w;
            c = idx % w;
            if (mode == 1) pix[idx] = (idx % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
            else           pix[idx] = DW'(base + idx);
            if (dut == 0) begin iv4 = 1'b1; in4 = pix[idx]; end
            else          begin iv8 = 1'b1; in8 = pix[idx]; end
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                logic [SB_W-1:0] e;
                e = {pix[idx-w-1], pix[idx-w], pix[idx-1], pix[idx], (idx == w*h-1)};
                if (dut == 0) exp4_q.push_back(e);
                else          exp8_q.push_back(e);
            end
            @(posedge clk); #1;
            iv4 = 1'b0;
            iv8 = 1'b0;
            in4 = 32'hDEAD_BEEF;
            in8 = 32'hDEAD_BEEF;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain();
        int budget;
        budget = 50;
        while ((exp4_q.size() != 0 || exp8_q.size() != 0) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check_eq("drain_q4", SB_W'(exp4_q.size()), '0);
        check_eq("drain_q8", SB_W'(exp8_q.size()), '0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- monitors (sample on falling edge) ----------------
    logic            rst_q  = 1'b1;
    logic            mon_en = 1'b0;
    logic [4*DW-1:0] hold4  = '0;
    logic [4*DW-1:0] hold8  = '0;

    always @(posedge clk) begin
        rst_q  <= rst;
        mon_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_q) begin
                check_eq("rst_out4", {a1, a2, a3, a4, ov4 | fd4}, '0);
                hold4 = '0;
            end else if (ov4) begin
                if (exp4_q.size() == 0) check_eq("spurious4", 1, 0);
                else check_eq("win4", {a1, a2, a3, a4, fd4}, exp4_q.pop_front());
                hold4 = {a1, a2, a3, a4};
            end else begin
                check_eq("hold4", {a1, a2, a3, a4, fd4}, {hold4, 1'b0});
            end

            if (rst_q) begin
                check_eq("rst_out8", {b1, b2, b3, b4, ov8 | fd8}, '0);
                hold8 = '0;
            end else if (ov8) begin
                if (exp8_q.size() == 0) check_eq("spurious8", 1, 0);
                else check_eq("win8", {b1, b2, b3, b4, fd8}, exp8_q.pop_front());
                hold8 = {b1, b2, b3, b4};
            end else begin
                check_eq("hold8", {b1, b2, b3, b4, fd8}, {hold8, 1'b0});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        iv4 = 1'b0; iv8 = 1'b0;
        in4 = '0;   in8 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // back-to-back frame 1..16
        drive_frame(0, 4, 4, 16, 1, 0, 0);
        drain();

        // same frame with 3 idle cycles after each pixel
        drive_frame(0, 4, 4, 16, 1, 0, 3);
        drain();

        // two frames with no dead cycle
        drive_frame(0, 4, 4, 16, 1, 0, 0);
        drive_frame(0, 4, 4, 16, 101, 0, 0);
        drain();

        // abort after 7 pixels: the window closed by pixel 6 is emitted before
        // the reset; nothing of that frame appears afterwards
        drive_frame(0, 4, 4, 7, 201, 0, 0);
        pulse_reset();
        repeat (2) begin @(posedge clk); #1; end
        drive_frame(0, 4, 4, 16, 1, 0, 0);
        drain();

        // reset and a valid pixel in the same cycle: pixel dropped
        rst = 1'b1; iv4 = 1'b1; in4 = 32'd999;
        @(posedge clk); #1;
        rst = 1'b0; iv4 = 1'b0;
        drive_frame(0, 4, 4, 16, 1, 0, 0);
        drain();

        // default 8x8 frame, alternating all-ones / all-zeros
        drive_frame(1, 8, 8, 64, 0, 1, 0);
        drain();

        repeat (4) begin @(posedge clk); #1; end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
